// File: rtl/rotary_encoder_pkg.sv
// Shared quadrature definitions for the rotary encoder counter.
// Phase encoding is {A,B}; forward rotation walks 00 -> 01 -> 11 -> 10 -> 00.
package rotary_encoder_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  localparam int DETENT_COUNT = 4;

  typedef enum logic [1:0] {
    QD_NONE,
    QD_FWD,
    QD_REV,
    QD_ILLEGAL
  } quad_delta_e;

  function automatic logic [1:0] fwd_next(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

  // Classifies one sampled transition; both bits flipping means a phase was missed.
  function automatic quad_delta_e quad_delta(input logic [1:0] prev, input logic [1:0] cur);
    if (prev == cur)                return QD_NONE;
    else if ((prev ^ cur) == 2'b11) return QD_ILLEGAL;
    else if (cur == fwd_next(prev)) return QD_FWD;
    else                            return QD_REV;
  endfunction

endpackage

// File: rtl/quad_step_detect.sv
// Tracks quadrature phase progress and reports completed detents and illegal jumps.
// inc_step/dec_step are the same-edge strobes; the *_pulse outputs are their registered copies.
module quad_step_detect
  import rotary_encoder_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enc_a,
  input  logic enc_b,
  output logic inc_step,
  output logic dec_step,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic err_pulse
);

  localparam logic signed [3:0] ACC_FWD = 4'(DETENT_COUNT);
  localparam logic signed [3:0] ACC_REV = -ACC_FWD;

  logic [1:0]        ab_q;
  logic [1:0]        cur;
  logic signed [3:0] acc;
  logic signed [3:0] acc_d;
  logic signed [3:0] acc_sum;
  logic              err_d;
  quad_delta_e       dir;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cur      = {enc_a, enc_b};
    dir      = quad_delta(ab_q, cur);
    acc_d    = acc;
    acc_sum  = acc;
    inc_step = 1'b0;
    dec_step = 1'b0;
    err_d    = 1'b0;
    case (dir)
      QD_FWD:  acc_sum = acc + 4'sd1;
      QD_REV:  acc_sum = acc - 4'sd1;
      default: ;
    endcase
    case (dir)
      QD_NONE: ;
      QD_ILLEGAL: begin
        err_d = 1'b1;
        acc_d = '0;
      end
      default: begin
        // Reaching the detent always clears progress; only a full cycle counts.
        if (cur == PH_00) begin
          acc_d    = '0;
          inc_step = (acc_sum == ACC_FWD);
          dec_step = (acc_sum == ACC_REV);
        end else begin
          acc_d = acc_sum;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ab_q      <= cur;
      acc       <= '0;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      ab_q      <= cur;
      acc       <= acc_d;
      inc_pulse <= inc_step;
      dec_pulse <= dec_step;
      err_pulse <= err_d;
    end
  end

endmodule

// File: rtl/rotary_encoder_counter.sv
// Per-channel setting register driven by a quadrature encoder, with saturate/wrap
// arithmetic and a synchronous preload that takes priority over steps.
module rotary_encoder_counter
  import rotary_encoder_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int STEP        = 1,
  parameter int WRAP        = 0,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             inc_pulse,
  output logic             dec_pulse,
  output logic             err_pulse
);

  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VALUE);

  logic             inc_step;
  logic             dec_step;
  logic [WIDTH:0]   sum_up;
  logic [WIDTH:0]   sum_dn;
  logic [WIDTH-1:0] value_d;

  quad_step_detect u_detect (
    .clk       (clk),
    .reset     (reset),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .inc_step  (inc_step),
    .dec_step  (dec_step),
    .inc_pulse (inc_pulse),
    .dec_pulse (dec_pulse),
    .err_pulse (err_pulse)
  );

  // The extra top bit is the carry on increment and the borrow on decrement.
  always_comb begin
    sum_up  = {1'b0, value} + STEP_W;
    sum_dn  = {1'b0, value} - STEP_W;
    value_d = value;
    if (load) begin
      value_d = load_value;
    end else if (inc_step) begin
      if (WRAP == 0 && sum_up[WIDTH]) value_d = '1;
      else                            value_d = sum_up[WIDTH-1:0];
    end else if (dec_step) begin
      if (WRAP == 0 && sum_dn[WIDTH]) value_d = '0;
      else                            value_d = sum_dn[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) value <= RST_V;
    else       value <= value_d;
  end

endmodule

// File: tb/tb_rotary_encoder_counter.sv
// Drives three counter configurations (default, wrapping, STEP=4 with nonzero reset value)
// from shared encoder lines and checks them against a phase-index reference model.
module tb_rotary_encoder_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enc_a;
  logic       enc_b;
  logic       load;
  logic [7:0] load_value;

  logic [7:0] val_a, val_w, val_s;
  logic       inc_a, dec_a, err_a;
  logic       inc_w, dec_w, err_w;
  logic       inc_s, dec_s, err_s;

  int n_checks = 0;
  int n_fail   = 0;
  int n_inc    = 0;
  int n_dec    = 0;
  int n_err    = 0;

  localparam int STEP_S = 4;
  localparam int RV_S   = 32;

  always #5 clk = ~clk;

  rotary_encoder_counter u_dut_a (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .load(load), .load_value(load_value), .value(val_a),
    .inc_pulse(inc_a), .dec_pulse(dec_a), .err_pulse(err_a)
  );

  rotary_encoder_counter #(.WIDTH(8), .STEP(1), .WRAP(1), .RESET_VALUE(0)) u_dut_w (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .load(load), .load_value(load_value), .value(val_w),
    .inc_pulse(inc_w), .dec_pulse(dec_w), .err_pulse(err_w)
  );

  rotary_encoder_counter #(.WIDTH(8), .STEP(STEP_S), .WRAP(0), .RESET_VALUE(RV_S)) u_dut_s (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .load(load), .load_value(load_value), .value(val_s),
    .inc_pulse(inc_s), .dec_pulse(dec_s), .err_pulse(err_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int phase_idx(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int apply(input int v, input bit up, input int step, input bit wrap);
    int r;
    r = up ? v + step : v - step;
    if (wrap) return (r + 256) % 256;
    if (r > 255) return 255;
    if (r < 0) return 0;
    return r;
  endfunction

  int m_prev, m_acc;
  bit m_inc, m_dec, m_err;
  int m_va, m_vw, m_vs;
  bit model_valid = 1'b0;

  always @(posedge clk) begin : model
    int cur, d, s, na, nw, ns;
    bit pi, pd, pe;
    int nacc;
    cur  = phase_idx(enc_a, enc_b);
    pi   = 1'b0;
    pd   = 1'b0;
    pe   = 1'b0;
    nacc = m_acc;
    na   = m_va;
    nw   = m_vw;
    ns   = m_vs;
    if (reset) begin
      nacc = 0;
      na   = 0;
      nw   = 0;
      ns   = RV_S;
    end else begin
      d = (cur - m_prev + 4) % 4;
      if (d == 2) begin
        pe   = 1'b1;
        nacc = 0;
      end else if (d != 0) begin
        s = m_acc + ((d == 1) ? 1 : -1);
        if (cur == 0) begin
          pi   = (s == 4);
          pd   = (s == -4);
          nacc = 0;
        end else begin
          nacc = s;
        end
      end
      if (load) begin
        na = int'(load_value);
        nw = int'(load_value);
        ns = int'(load_value);
      end else if (pi || pd) begin
        na = apply(m_va, pi, 1, 1'b0);
        nw = apply(m_vw, pi, 1, 1'b1);
        ns = apply(m_vs, pi, STEP_S, 1'b0);
      end
    end
    m_prev      <= cur;
    m_acc       <= nacc;
    m_inc       <= pi;
    m_dec       <= pd;
    m_err       <= pe;
    m_va        <= na;
    m_vw        <= nw;
    m_vs        <= ns;
    model_valid <= 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_valid) begin
      check("val_a", val_a, m_va);
      check("val_w", val_w, m_vw);
      check("val_s", val_s, m_vs);
      check("inc_a", inc_a, m_inc);
      check("dec_a", dec_a, m_dec);
      check("err_a", err_a, m_err);
      check("inc_w", inc_w, m_inc);
      check("dec_w", dec_w, m_dec);
      check("err_w", err_w, m_err);
      check("inc_s", inc_s, m_inc);
      check("dec_s", dec_s, m_dec);
      check("err_s", err_s, m_err);
      check("onehot", 32'(inc_a) + 32'(dec_a) + 32'(err_a) <= 1, 1);
      if (inc_a) n_inc++;
      if (dec_a) n_dec++;
      if (err_a) n_err++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step_ab(input logic [1:0] ab, input int hold);
    {enc_a, enc_b} = ab;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic fwd_detent();
    step_ab(2'b01, 3);
    step_ab(2'b11, 3);
    step_ab(2'b10, 3);
    step_ab(2'b00, 3);
  endtask

  task automatic rev_detent();
    step_ab(2'b10, 3);
    step_ab(2'b11, 3);
    step_ab(2'b01, 3);
    step_ab(2'b00, 3);
  endtask

  task automatic do_load(input logic [7:0] v);
    load       = 1'b1;
    load_value = v;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    enc_a      = 1'b0;
    enc_b      = 1'b0;
    load       = 1'b0;
    load_value = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_val_a", val_a, 8'h00);
    check("rst_val_s", val_s, 8'h20);
    check("rst_pulses", {inc_a, dec_a, err_a}, 3'b000);
    reset = 1'b0;

    fwd_detent();
    check("fwd_val_a", val_a, 8'h01);
    check("fwd_val_s", val_s, 8'h24);
    check("fwd_n_inc", n_inc, 1);

    rev_detent();
    check("rev1_val_a", val_a, 8'h00);
    rev_detent();
    check("rev_sat0_a", val_a, 8'h00);
    check("rev_wrap_w", val_w, 8'hFF);
    check("rev_val_s", val_s, 8'h1C);
    check("rev_n_dec", n_dec, 2);

    do_load(8'd254);
    check("load_val_s", val_s, 8'hFE);
    fwd_detent();
    check("sat1_val_s", val_s, 8'hFF);
    check("sat1_val_w", val_w, 8'hFF);
    fwd_detent();
    check("sat2_val_s", val_s, 8'hFF);
    check("wrap_up_w", val_w, 8'h00);
    check("sat2_n_inc", n_inc, 3);

    step_ab(2'b01, 3);
    step_ab(2'b11, 3);
    step_ab(2'b01, 3);
    step_ab(2'b00, 3);
    check("bounce_n_inc", n_inc, 3);
    check("bounce_n_dec", n_dec, 2);
    check("bounce_val_a", val_a, 8'hFF);

    step_ab(2'b01, 3);
    step_ab(2'b10, 3);
    check("illegal_n_err", n_err, 1);
    step_ab(2'b00, 3);
    check("after_err_n_inc", n_inc, 3);
    fwd_detent();
    check("recover_n_inc", n_inc, 4);
    check("recover_val_w", val_w, 8'h01);

    step_ab(2'b01, 3);
    step_ab(2'b11, 3);
    step_ab(2'b10, 3);
    {enc_a, enc_b} = 2'b00;
    load       = 1'b1;
    load_value = 8'h80;
    @(posedge clk);
    #1;
    load = 1'b0;
    check("ldprio_val_a", val_a, 8'h80);
    check("ldprio_val_s", val_s, 8'h80);
    check("ldprio_inc_a", inc_a, 1'b1);
    step_ab(2'b00, 2);
    check("ldprio_n_inc", n_inc, 5);

    do_load(8'd2);
    rev_detent();
    check("dec_floor_s", val_s, 8'h00);
    check("dec_val_a", val_a, 8'h01);
    check("dec_n_dec", n_dec, 3);

    step_ab(2'b01, 3);
    step_ab(2'b11, 3);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_val_a", val_a, 8'h00);
    check("midrst_val_s", val_s, 8'h20);
    step_ab(2'b11, 2);
    step_ab(2'b10, 3);
    step_ab(2'b00, 3);
    check("midrst_n_inc", n_inc, 5);
    check("midrst_n_err", n_err, 1);
    check("midrst_val_a2", val_a, 8'h00);
    fwd_detent();
    check("post_rst_n_inc", n_inc, 6);
    check("post_rst_val_a", val_a, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
